// File: rtl/bicubic_upscale_stream.sv
// Streaming 4x Catmull-Rom bicubic upscaler with ping-pong x-stage banks.
// Optional BICUBIC_ROUND_EN: round half up before clamping (default truncates).
module bicubic_upscale_stream #(
  parameter int PIX_W = 8,
  parameter int CH    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sol,
  input  logic [CH*4*PIX_W-1:0] in_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*4*PIX_W-1:0] out_row,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = CH*4*PIX_W;
  localparam int XW = PIX_W+9;
  localparam int YW = PIX_W+17;
  localparam logic [PIX_W-1:0] PMAX = '1;
  localparam logic signed [YW-1:0] QMAX = YW'((1 << PIX_W) - 1);
  localparam logic signed [YW-1:0] HALF = YW'(8192);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // Taps packed oldest (i0) in the LSBs, 9-bit signed Q7
  function automatic logic [35:0] wrow(input logic [1:0] p);
    unique case (p)
      2'd0:    wrow = {9'sd0, 9'sd0, 9'sd128, 9'sd0};
      2'd1:    wrow = {-9'sd3, 9'sd29, 9'sd111, -9'sd9};
      2'd2:    wrow = {-9'sd8, 9'sd72, 9'sd72, -9'sd8};
      default: wrow = {-9'sd9, 9'sd111, 9'sd29, -9'sd3};
    endcase
  endfunction

  function automatic logic signed [8:0] wsel(
    input logic [1:0] p,
    input int         i
  );
    logic [35:0] w;
    w = wrow(p);
    return $signed(w[i*9 +: 9]);
  endfunction

  function automatic logic signed [XW-1:0] xdot(
    input logic [PIX_W-1:0] a0,
    input logic [PIX_W-1:0] a1,
    input logic [PIX_W-1:0] a2,
    input logic [PIX_W-1:0] a3,
    input logic [1:0]       p
  );
    logic signed [XW-1:0] s;
    s = XW'(wsel(p, 0)) * $signed(XW'({1'b0, a0}))
      + XW'(wsel(p, 1)) * $signed(XW'({1'b0, a1}))
      + XW'(wsel(p, 2)) * $signed(XW'({1'b0, a2}))
      + XW'(wsel(p, 3)) * $signed(XW'({1'b0, a3}));
    return s;
  endfunction

  function automatic logic signed [YW-1:0] ydot(
    input logic signed [XW-1:0] a0,
    input logic signed [XW-1:0] a1,
    input logic signed [XW-1:0] a2,
    input logic signed [XW-1:0] a3,
    input logic [1:0]           r
  );
    logic signed [YW-1:0] s;
    s = YW'(wsel(r, 0)) * YW'(a0)
      + YW'(wsel(r, 1)) * YW'(a1)
      + YW'(wsel(r, 2)) * YW'(a2)
      + YW'(wsel(r, 3)) * YW'(a3);
    return s;
  endfunction

  function automatic logic [PIX_W-1:0] clampq(
    input logic signed [YW-1:0] s
  );
    logic signed [YW-1:0] q;
`ifdef BICUBIC_ROUND_EN
    q = (s + HALF) >>> 14;
`else
    q = s >>> 14;
`endif
    if (q[YW-1])  return '0;
    if (q > QMAX) return PMAX;
    return q[PIX_W-1:0];
  endfunction

  logic [CW-1:0]        r_win [4];
  logic [2:0]           r_cnt;
  logic [1:0]           r_full;
  logic [1:0]           r_done;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic                 r_xgo;
  logic                 r_xbank;
  state_t               r_state;
  logic [1:0]           r_row;
  logic signed [XW-1:0] r_bank [2][CH][4][4];

  logic                 w_acc;
  logic                 w_trig;
  logic [2:0]           w_cnt_nx;
  logic                 w_hs;
  logic                 w_fin;
  logic                 w_ybank;
  logic [1:0]           w_yrow;
  logic [CW-1:0]        w_ypix;
  logic signed [XW-1:0] w_x [CH][4][4];

  assign in_ready = !r_full[r_wr_ptr];
  assign w_acc    = in_valid && in_ready;
  assign w_trig   = w_acc && (w_cnt_nx == 3'd4);
  assign w_hs     = out_valid && out_ready;
  assign w_fin    = w_hs && (r_row == 2'd3);
  assign busy     = (|r_full) || out_valid;

  always_comb begin
    w_cnt_nx = r_cnt + 3'd1;
    if (in_sol)
      w_cnt_nx = 3'd1;
    else if (r_cnt == 3'd4)
      w_cnt_nx = 3'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        r_win[i] <= '0;
      r_cnt    <= '0;
      r_wr_ptr <= 1'b0;
      r_xgo    <= 1'b0;
      r_xbank  <= 1'b0;
    end else begin
      r_xgo <= w_trig;
      if (w_acc) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= r_win[3];
        r_win[3] <= in_col;
        r_cnt    <= w_cnt_nx;
      end
      if (w_trig) begin
        r_wr_ptr <= ~r_wr_ptr;
        r_xbank  <= r_wr_ptr;
      end
    end
  end

  // full reserves a bank at trigger; done marks its x data written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
      r_done <= '0;
    end else begin
      if (w_fin) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_done[r_rd_ptr] <= 1'b0;
      end
      if (w_trig)
        r_full[r_wr_ptr] <= 1'b1;
      if (r_xgo)
        r_done[r_xbank] <= 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++)
      for (int j = 0; j < 4; j++)
        for (int p = 0; p < 4; p++)
          w_x[c][j][p] = xdot(
            r_win[0][(c*4+j)*PIX_W +: PIX_W],
            r_win[1][(c*4+j)*PIX_W +: PIX_W],
            r_win[2][(c*4+j)*PIX_W +: PIX_W],
            r_win[3][(c*4+j)*PIX_W +: PIX_W],
            2'(p));
  end

  always_ff @(posedge clk) begin
    if (r_xgo)
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < 4; j++)
          for (int p = 0; p < 4; p++)
            r_bank[r_xbank][c][j][p] <= w_x[c][j][p];
  end

  always_comb begin
    w_ybank = w_fin ? ~r_rd_ptr : r_rd_ptr;
    w_yrow  = 2'd0;
    if (r_state == S_EMIT && w_hs && !w_fin)
      w_yrow = r_row + 2'd1;
    w_ypix = '0;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < 4; p++)
        w_ypix[(c*4+p)*PIX_W +: PIX_W] = clampq(ydot(
          r_bank[w_ybank][c][0][p],
          r_bank[w_ybank][c][1][p],
          r_bank[w_ybank][c][2][p],
          r_bank[w_ybank][c][3][p],
          w_yrow));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_rd_ptr  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_done[r_rd_ptr]) begin
            out_valid <= 1'b1;
            out_row   <= w_ypix;
            out_last  <= 1'b0;
            r_row     <= 2'd0;
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            if (w_fin) begin
              r_rd_ptr <= ~r_rd_ptr;
              r_row    <= 2'd0;
              out_last <= 1'b0;
              if (r_done[~r_rd_ptr]) begin
                out_row <= w_ypix;
              end else begin
                out_valid <= 1'b0;
                r_state   <= S_IDLE;
              end
            end else begin
              r_row    <= r_row + 2'd1;
              out_row  <= w_ypix;
              out_last <= (r_row == 2'd2);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_upscale_stream.sv
// Directed bench for bicubic_upscale_stream (PIX_W=8, CH=1).
// Expected rows are hand-computed Catmull-Rom results.
module tb_bicubic_upscale_stream;

`ifdef BICUBIC_ROUND_EN
  localparam logic [7:0] V57 = 8'd58;
`else
  localparam logic [7:0] V57 = 8'd57;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sol = 1'b0;
  logic [31:0] in_col = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_row;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bicubic_upscale_stream #(.PIX_W(8), .CH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sol    (in_sol),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all4(input logic [7:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [31:0] ph(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic push(input logic sol, input logic [31:0] col);
    int n = 0;
    in_valid = 1'b1;
    in_sol   = sol;
    in_col   = col;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic tile4(input logic [31:0] c0, input logic [31:0] c1,
                       input logic [31:0] c2, input logic [31:0] c3);
    push(1'b1, c0);
    push(1'b0, c1);
    push(1'b0, c2);
    push(1'b0, c3);
  endtask

  task automatic get_row(output logic [31:0] row, output logic last,
                         output int waits);
    waits = 0;
    out_ready = 1'b1;
    while (!out_valid && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!out_valid) check("row_timeout", 64'(out_valid), 64'd1);
    row  = out_row;
    last = out_last;
    @(posedge clk); #1;
  endtask

  task automatic expect_tile(input string tag,
                             input logic [31:0] r0, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] r3,
                             input logic nobubble);
    logic [31:0] e [4];
    logic [31:0] row;
    logic        last;
    int          waits;
    e = '{r0, r1, r2, r3};
    for (int k = 0; k < 4; k++) begin
      get_row(row, last, waits);
      check($sformatf("%s_row%0d", tag, k), 64'(row), 64'(e[k]));
      check($sformatf("%s_last%0d", tag, k), 64'(last), 64'(k == 3));
      if (nobubble)
        check($sformatf("%s_gap%0d", tag, k), 64'(waits), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] row;
    logic        last;
    int          waits;
    logic        seen;

    @(posedge clk); #1;
    check("rst_out", 64'({out_valid, out_last, out_row}), 64'd0);
    check("rst_flags", 64'({busy, in_ready}), 64'b01);
    rst = 1'b1;
    @(posedge clk); #1;

    // constant field and first-row latency
    out_ready = 1'b0;
    tile4(all4(100), all4(100), all4(100), all4(100));
    check("lat0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat2", 64'(out_valid), 64'd1);
    check("busy_emit", 64'(busy), 64'd1);
    expect_tile("const", all4(100), all4(100), all4(100), all4(100), 1'b1);

    // vertical-only variation
    tile4(ph(0, 0, 255, 0), ph(0, 0, 255, 0),
          ph(0, 0, 255, 0), ph(0, 0, 255, 0));
    expect_tile("vert", all4(0), all4(V57), all4(143), all4(221), 1'b0);

    tile4(all4(0), all4(0), all4(255), all4(0));
    expect_tile("horz", ph(0, V57, 143, 221), ph(0, V57, 143, 221),
                ph(0, V57, 143, 221), ph(0, V57, 143, 221), 1'b0);

    tile4(all4(255), all4(0), all4(0), all4(0));
    expect_tile("clamplo", all4(0), all4(0), all4(0), all4(0), 1'b0);

    tile4(all4(0), all4(255), all4(255), all4(0));
    expect_tile("clamphi", all4(255), all4(255), all4(255), all4(255), 1'b0);

    // two tiles buffered under backpressure
    out_ready = 1'b0;
    tile4(all4(0), all4(0), all4(255), all4(0));
    check("rdy_t1", 64'(in_ready), 64'd1);
    push(1'b0, all4(0));
    check("rdy_t2", 64'(in_ready), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    held = out_row;
    check("stall_first", 64'({out_valid, held}),
          64'({1'b1, ph(0, V57, 143, 221)}));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall_hold%0d", k),
            64'({out_valid, out_last, in_ready, out_row}),
            64'({1'b1, 1'b0, 1'b0, held}));
    end
    expect_tile("bp_t1", ph(0, V57, 143, 221), ph(0, V57, 143, 221),
                ph(0, V57, 143, 221), ph(0, V57, 143, 221), 1'b1);
    expect_tile("bp_t2", ph(255, 221, 143, V57), ph(255, 221, 143, V57),
                ph(255, 221, 143, V57), ph(255, 221, 143, V57), 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("bp_drain", 64'({out_valid, busy, in_ready}), 64'b001);

    // in_sol restarts the column count
    push(1'b1, all4(255));
    push(1'b0, all4(255));
    push(1'b1, all4(0));
    push(1'b0, all4(0));
    push(1'b0, all4(255));
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("sol_wait", 64'(out_valid), 64'd0);
    push(1'b0, all4(0));
    expect_tile("sol", ph(0, V57, 143, 221), ph(0, V57, 143, 221),
                ph(0, V57, 143, 221), ph(0, V57, 143, 221), 1'b0);

    // reset while row 1 is on the output
    tile4(all4(100), all4(100), all4(100), all4(100));
    get_row(row, last, waits);
    check("mr_row0", 64'(row), 64'(all4(100)));
    out_ready = 1'b0;
    check("mr_row1_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mr_out", 64'({out_valid, out_last, out_row}), 64'd0);
    check("mr_flags", 64'({busy, in_ready}), 64'b01);
    rst = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("mr_stale", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
